de_hazard_ctrl: RTL

Stall/flush controller for the decode-to-execute boundary of the five-stage pipeline. Each cycle it compares the source registers of the instruction in D against the pending destinations in E and M, and decides whether the instruction may advance. If not, it freezes PC and the F/D register and loads a bubble (all-zero instruction) into the D/E register. It also schedules the shared multi-cycle multiply/divide unit and keeps a saturating stall-cycle counter.

---
 rtl/de_hazard_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/de_hazard_ctrl.sv
// Decode/execute hazard controller: stalls D on data or md-unit hazards, flushes D/E.
// Optional md-unit scheduling is compiled in with the macro MD_UNIT_EN.
module de_hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rs_addr,
   input  logic [4:0]  d_rt_addr,
   input  logic [1:0]  d_rs_tuse,
   input  logic [1:0]  d_rt_tuse,
   input  logic [4:0]  e_wa,
   input  logic [1:0]  e_tnew,
   input  logic [4:0]  m_wa,
   input  logic [1:0]  m_tnew,
   input  logic        d_is_md,
   input  logic        e_md_start,
   input  logic        e_md_div,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_flush,
   output logic        md_busy,
   output logic [31:0] stall_count
);

   localparam logic [1:0]       TUSE_NONE = 2'd3;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   // A source is hazardous when a younger-needed value is produced too late by E or M.
   function automatic logic src_hazard(
      input logic [4:0] addr,
      input logic [1:0] tuse,
      input logic [4:0] ewa,
      input logic [1:0] etnew,
      input logic [4:0] mwa,
      input logic [1:0] mtnew
   );
      logic e_hit;
      logic m_hit;
      e_hit = (addr == ewa) && (tuse < etnew);
      m_hit = (addr == mwa) && (tuse < mtnew);
      return (addr != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
   endfunction

   logic rs_hazard;
   logic rt_hazard;
   logic md_hazard;
   logic stall;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rs_hazard = 1'b0;
      rt_hazard = 1'b0;
      stall     = 1'b0;
      rs_hazard = src_hazard(d_rs_addr, d_rs_tuse, e_wa, e_tnew, m_wa, m_tnew);
      rt_hazard = src_hazard(d_rt_addr, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew);
      stall     = rs_hazard | rt_hazard | md_hazard;
   end

   assign pc_en    = ~stall;
   assign fd_en    = ~stall;
   assign de_flush = stall;

`ifdef MD_UNIT_EN
   typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

   md_state_t        md_state;
   logic [CNT_W-1:0] md_cnt;
   logic             md_busy_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         md_state  <= MD_IDLE;
         md_cnt    <= '0;
         md_busy_q <= 1'b0;
      end else begin
         case (md_state)
            MD_IDLE: begin
               if (e_md_start) begin
                  md_cnt    <= e_md_div ? DIV_LOAD : MULT_LOAD;
                  md_state  <= MD_BUSY;
                  md_busy_q <= 1'b1;
               end
            end
            MD_BUSY: begin
               // A start arriving while busy is dropped; the pipeline never issues one.
               md_cnt <= md_cnt - CNT_W'(1);
               if (md_cnt == CNT_W'(1)) begin
                  md_state  <= MD_IDLE;
                  md_busy_q <= 1'b0;
               end
            end
            default: begin
               md_state  <= MD_IDLE;
               md_cnt    <= '0;
               md_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign md_hazard = d_is_md & (md_busy_q | e_md_start);
   assign md_busy   = md_busy_q;
`else
   logic unused_md;
   assign unused_md = ^{d_is_md, e_md_start, e_md_div, MULT_LOAD, DIV_LOAD};
   assign md_hazard = 1'b0;
   assign md_busy   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end

endmodule
